// File: rtl/sr_serial_ctrl_pkg.sv
// Shared definitions for the serial shift-register controller: FSM encodings,
// default word width and the frame length (data bits plus optional parity bit).
// Optional feature macro: SR_SERIAL_PARITY_EN (adds one even-parity bit per frame).
package sr_serial_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

`ifdef SR_SERIAL_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Number of serial bits per frame: the data word, plus the parity bit when built in.
    function automatic int frame_len(input int width);
        return PARITY_EN ? width + 1 : width;
    endfunction

endpackage

// File: rtl/sr_bit_counter.sv
// Loadable, enable-gated up-counter with a terminal-count flag.
// Latency: count updates one cycle after en/load; tc is combinational from the count.
// Backpressure: none; the caller gates en with its own handshake.
module sr_bit_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // Count register: load (clear) wins over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Terminal count marks the last bit index of the frame.
    always_comb begin
        tc = (cnt == term_val);
    end

endmodule

// File: rtl/sr_serial_ctrl.sv
// Serializes a parallel word MSB first, one bit per accepted cycle, with done pulse.
// Latency: first bit the cycle after capture; done FRAME_LEN+1 cycles after capture.
// Backpressure: sout_ready=0 freezes the current bit indefinitely; din_ready only in IDLE.
// Optional feature macro: SR_SERIAL_PARITY_EN appends an even-parity bit to each frame.
module sr_serial_ctrl
    import sr_serial_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             sout_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int FRAME_LEN = frame_len(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic             capture;
    logic             last_bit;
    logic             data_bit;

    assign capture = din_valid & din_ready;

    // Bit index; it stops at the last index so it never runs past the frame.
    sr_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (capture),
        .en       (shift_en & ~last_bit),
        .term_val (CNT_W'(FRAME_LEN - 1)),
        .cnt      (bit_cnt),
        .tc       (last_bit)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: the final accepted bit moves to the one-cycle DONE state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = SHIFT;
            SHIFT:   if (shift_en && last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register: load on capture, shift left with zero fill on each accepted bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= '0;
        end else if (capture) begin
            shreg <= din;
        end else if (shift_en) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef SR_SERIAL_PARITY_EN
    logic par_bit;

    // Even parity of the captured word, held for the trailing frame bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            par_bit <= 1'b0;
        end else if (capture) begin
            par_bit <= ^din;
        end
    end

    // After the data bits have drained, the parity flop drives the line.
    always_comb begin
        data_bit = (bit_cnt == CNT_W'(WIDTH)) ? par_bit : shreg[WIDTH-1];
    end
`else
    // The line always carries the register MSB.
    always_comb begin
        data_bit = shreg[WIDTH-1];
    end
`endif

    // Output decode from the current state.
    always_comb begin
        din_ready  = 1'b0;
        busy       = 1'b0;
        sout_valid = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                din_ready = 1'b1;
            end
            SHIFT: begin
                busy       = 1'b1;
                sout_valid = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                din_ready = 1'b0;
            end
        endcase
        sout     = sout_valid & data_bit;
        shift_en = sout_valid & sout_ready;
    end

endmodule

// File: tb/tb_sr_serial_ctrl.sv
// Directed bench for sr_serial_ctrl: reset, serialization, stalls, busy ignore,
// mid-frame reset, back-to-back frames and (parity build) the trailing parity bit.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sr_serial_ctrl;

`ifdef SR_SERIAL_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic       sout_ready;
    logic       sout;
    logic       sout_valid;
    logic       shift_en;
    logic       busy;
    logic       done;
    logic [4:0] bit_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    sr_serial_ctrl #(.WIDTH(8), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sout_ready (sout_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .shift_en   (shift_en),
        .busy       (busy),
        .done       (done),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    // Expected frame, MSB-first bit i at index FL-1-i.
    function automatic logic [8:0] exp_frame(input logic [7:0] w);
`ifdef SR_SERIAL_PARITY_EN
        return {w, ^w};
`else
        return {1'b0, w};
`endif
    endfunction

    task automatic test_reset();
        reset = 1'b1; din = 8'h00; din_valid = 1'b0; sout_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b1 || busy !== 1'b0 || sout_valid !== 1'b0 || done !== 1'b0 ||
            bit_cnt !== 5'd0 || sout !== 1'b0 || shift_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: rdy=%b busy=%b vld=%b done=%b cnt=%0d sout=%b en=%b, want 1 0 0 0 0 0 0",
                     din_ready, busy, sout_valid, done, bit_cnt, sout, shift_en);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [8:0] ef;
        ef = exp_frame(8'hA5);
        din = 8'hA5; din_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (sout_valid !== 1'b1 || sout !== ef[FL-1-i] || bit_cnt !== 5'(i) ||
                shift_en !== 1'b1 || busy !== 1'b1 || din_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL basic_bit%0d: vld=%b sout=%b cnt=%0d en=%b busy=%b rdy=%b, want 1 %b %0d 1 1 0",
                         i, sout_valid, sout, bit_cnt, shift_en, busy, din_ready, ef[FL-1-i], i);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || sout_valid !== 1'b0 || busy !== 1'b1 || din_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done: done=%b vld=%b busy=%b rdy=%b, want 1 0 1 0", done, sout_valid, busy, din_ready);
        end
        @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_idle: rdy=%b done=%b busy=%b, want 1 0 0", din_ready, done, busy);
        end
    endtask

    task automatic test_stall();
        logic [8:0] ef;
        int k;
        int stall;
        ef = exp_frame(8'h3C);
        k = 0; stall = 3;
        din = 8'h3C; din_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int c = 0; c < FL + 3; c++) begin
            if (k == 2 && stall > 0) begin
                sout_ready = 1'b0;
                stall--;
            end else begin
                sout_ready = 1'b1;
            end
            #1;
            tests_run++;
            if (sout_valid !== 1'b1 || sout !== ef[FL-1-k] || bit_cnt !== 5'(k) || shift_en !== sout_ready) begin
                tests_failed++;
                $display("FAIL stall_c%0d: vld=%b sout=%b cnt=%0d en=%b, want 1 %b %0d %b",
                         c, sout_valid, sout, bit_cnt, shift_en, ef[FL-1-k], k, sout_ready);
            end
            if (sout_ready) k++;
            @(negedge clk);
        end
        sout_ready = 1'b1;
        tests_run++;
        if (done !== 1'b1 || sout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_done: done=%b vld=%b, want 1 0", done, sout_valid);
        end
        @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_idle: rdy=%b, want 1", din_ready);
        end
    endtask

    task automatic test_busy_ignore();
        logic [8:0] ef1;
        logic [8:0] ef2;
        ef1 = exp_frame(8'hFF);
        ef2 = exp_frame(8'h01);
        din = 8'hFF; din_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < FL; i++) begin
            if (i == 2) din = 8'h55;
            if (i == 5) din = 8'h01;
            #1;
            tests_run++;
            if (sout_valid !== 1'b1 || sout !== ef1[FL-1-i] || bit_cnt !== 5'(i)) begin
                tests_failed++;
                $display("FAIL busy_f1_bit%0d: vld=%b sout=%b cnt=%0d, want 1 %b %0d",
                         i, sout_valid, sout, bit_cnt, ef1[FL-1-i], i);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1 || din_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_done: done=%b rdy=%b, want 1 0", done, din_ready);
        end
        @(negedge clk);
        tests_run++;
        if (din_ready !== 1'b1 || sout_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ready_back: rdy=%b vld=%b, want 1 0", din_ready, sout_valid);
        end
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (sout_valid !== 1'b1 || sout !== ef2[FL-1-i] || bit_cnt !== 5'(i)) begin
                tests_failed++;
                $display("FAIL busy_f2_bit%0d: vld=%b sout=%b cnt=%0d, want 1 %b %0d",
                         i, sout_valid, sout, bit_cnt, ef2[FL-1-i], i);
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [8:0] ef;
        logic       bad;
        ef = exp_frame(8'hF0);
        bad = 1'b0;
        din = 8'hF0; din_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (sout_valid !== 1'b1 || sout !== ef[FL-1-i] || bit_cnt !== 5'(i)) begin
                tests_failed++;
                $display("FAIL rmid_bit%0d: vld=%b sout=%b cnt=%0d, want 1 %b %0d",
                         i, sout_valid, sout, bit_cnt, ef[FL-1-i], i);
            end
            if (i < 4) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tests_run++;
        if (sout_valid !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1 || bit_cnt !== 5'd0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_after: vld=%b busy=%b rdy=%b cnt=%0d done=%b, want 0 0 1 0 0",
                     sout_valid, busy, din_ready, bit_cnt, done);
        end
        for (int c = 0; c < FL + 2; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || sout_valid !== 1'b0) bad = 1'b1;
        end
        tests_run++;
        if (bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL rmid_quiet: stray done or sout_valid seen=%b, want 0", bad);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] ef1;
        logic [8:0] ef2;
        ef1 = exp_frame(8'h80);
        ef2 = exp_frame(8'h01);
        din = 8'h80; din_valid = 1'b1; sout_ready = 1'b1;
        @(negedge clk);
        din = 8'h01;
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (sout_valid !== 1'b1 || sout !== ef1[FL-1-i] || bit_cnt !== 5'(i)) begin
                tests_failed++;
                $display("FAIL b2b_f1_bit%0d: vld=%b sout=%b cnt=%0d, want 1 %b %0d",
                         i, sout_valid, sout, bit_cnt, ef1[FL-1-i], i);
            end
            @(negedge clk);
        end
        tests_run++;
        if (sout_valid !== 1'b0 || done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap_done: vld=%b done=%b, want 0 1", sout_valid, done);
        end
        @(negedge clk);
        tests_run++;
        if (sout_valid !== 1'b0 || din_ready !== 1'b1 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_gap_idle: vld=%b rdy=%b done=%b, want 0 1 0", sout_valid, din_ready, done);
        end
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            tests_run++;
            if (sout_valid !== 1'b1 || sout !== ef2[FL-1-i] || bit_cnt !== 5'(i)) begin
                tests_failed++;
                $display("FAIL b2b_f2_bit%0d: vld=%b sout=%b cnt=%0d, want 1 %b %0d",
                         i, sout_valid, sout, bit_cnt, ef2[FL-1-i], i);
            end
            @(negedge clk);
        end
        tests_run++;
        if (done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_f2_done: done=%b, want 1", done);
        end
        @(negedge clk);
    endtask

`ifdef SR_SERIAL_PARITY_EN
    task automatic test_parity();
        logic [7:0] words [2];
        logic [8:0] seqs  [2];
        words[0] = 8'h07; seqs[0] = 9'b000001111;
        words[1] = 8'h03; seqs[1] = 9'b000000110;
        for (int w = 0; w < 2; w++) begin
            din = words[w]; din_valid = 1'b1; sout_ready = 1'b1;
            @(negedge clk);
            din_valid = 1'b0;
            for (int i = 0; i < 9; i++) begin
                tests_run++;
                if (sout_valid !== 1'b1 || sout !== seqs[w][8-i] || bit_cnt !== 5'(i)) begin
                    tests_failed++;
                    $display("FAIL parity_w%0d_bit%0d: vld=%b sout=%b cnt=%0d, want 1 %b %0d",
                             w, i, sout_valid, sout, bit_cnt, seqs[w][8-i], i);
                end
                @(negedge clk);
            end
            tests_run++;
            if (done !== 1'b1) begin
                tests_failed++;
                $display("FAIL parity_w%0d_done: done=%b, want 1", w, done);
            end
            @(negedge clk);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
`ifdef SR_SERIAL_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
